multicycle_ctrl: RTL and testbench

- Moore-style control FSM that sequences a shared-memory, single-ALU multicycle datapath for the team's 3-bit-opcode MIPS subset: RTYPE, LW, SW, BEQ, ADDI, J.
- Drives mux selects and write enables on every cycle.
- Stalls on a memory ready handshake and keeps a count of retired instructions.
- Sits beside aludec, which consumes aluop, inside the multicycle controller wrapper.

---
 rtl/mc_pkg.sv | 59 +++++
 rtl/mc_outdec.sv | 71 +++++++
 rtl/multicycle_ctrl.sv | 106 ++++++++++
 tb/tb_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and select constants for the multicycle MIPS-subset controller.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } statetype_t;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_LW    = 3'b001;
  localparam logic [2:0] OP_SW    = 3'b010;
  localparam logic [2:0] OP_BEQ   = 3'b011;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
  } ctrl_t;

  function automatic logic is_illegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> control-word decoder; every field not set for a state stays 0.
module mc_outdec
  import mc_pkg::*;
(
  input  statetype_t state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALU_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        // IR and PC only latch once the fetch actually completes
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle datapath: state register, next-state logic,
// retired-instruction counter and reset-gated control outputs.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             branch,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_o
);

  statetype_t       state_reg, state_next;
  logic [CNT_W-1:0] retired_reg;
  logic             illegal_reg;
  logic             retire;
  ctrl_t            ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= FETCH;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    retire     = 1'b0;
    case (state_reg)
      FETCH:   state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_RTYPE:     state_next = RTYPEEX;
          OP_LW, OP_SW: state_next = MEMADR;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_next = mem_ready ? MEMWB : MEMRD;
      MEMWB:   begin state_next = FETCH; retire = 1'b1; end
      MEMWR:   begin state_next = mem_ready ? FETCH : MEMWR; retire = mem_ready; end
      RTYPEEX: state_next = ALUWB;
      ALUWB:   begin state_next = FETCH; retire = 1'b1; end
      BEQEX:   begin state_next = FETCH; retire = 1'b1; end
      ADDIEX:  state_next = ADDIWB;
      ADDIWB:  begin state_next = FETCH; retire = 1'b1; end
      JUMP:    begin state_next = FETCH; retire = 1'b1; end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_reg <= '0;
      illegal_reg <= 1'b0;
    end else begin
      if (retire) retired_reg <= retired_reg + 1'b1;
      illegal_reg <= (state_reg == DECODE) && is_illegal(op);
    end
  end

  mc_outdec u_outdec (
    .state     (state_reg),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Strobes are masked by reset_n so nothing fires while reset is held
  always_comb begin
    mem_req    = ctrl.mem_req  & reset_n;
    iord       = ctrl.iord;
    memwrite   = ctrl.memwrite & reset_n;
    irwrite    = ctrl.irwrite  & reset_n;
    pcwrite    = ctrl.pcwrite  & reset_n;
    branch     = ctrl.branch   & reset_n;
    pcsrc      = ctrl.pcsrc;
    alusrca    = ctrl.alusrca;
    alusrcb    = ctrl.alusrcb;
    aluop      = ctrl.aluop;
    regdst     = ctrl.regdst;
    memtoreg   = ctrl.memtoreg;
    regwrite   = ctrl.regwrite & reset_n;
    illegal_op = illegal_reg;
    retired    = retired_reg;
    state_o    = state_reg;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instruction-level driver pushes expected per-cycle
// observations, an independent monitor pops and compares on each falling edge.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       op;
  logic             mem_ready;
  logic             mem_req, iord, memwrite, irwrite, pcwrite, branch;
  logic [1:0]       pcsrc, alusrcb, aluop;
  logic             alusrca, regdst, memtoreg, regwrite, illegal_op;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state_o;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .illegal_op(illegal_op), .retired(retired), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [3:0]  ret;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_ret = 0;
  logic exp_ill = 1'b0;
  bit   drive_done = 1'b0;

  // Control word as listed per state: {mem_req,iord,memwrite,irwrite,pcwrite,branch,
  // pcsrc,alusrca,alusrcb,aluop,regdst,memtoreg,regwrite}
  function automatic logic [15:0] ctrl_of(input int st, input logic mr);
    logic mq, io, mw, irw, pcw, br, sa, rd, m2r, rw;
    logic [1:0] pcs, sb_sel, aop;
    {mq, io, mw, irw, pcw, br, sa, rd, m2r, rw} = '0;
    pcs = 2'b00; sb_sel = 2'b00; aop = 2'b00;
    case (st)
      0:  begin mq = 1; sb_sel = 2'b01; irw = mr; pcw = mr; end
      1:  sb_sel = 2'b11;
      2:  begin sa = 1; sb_sel = 2'b10; end
      3:  begin mq = 1; io = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mq = 1; io = 1; mw = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
      9:  begin sa = 1; sb_sel = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {mq, io, mw, irw, pcw, br, pcs, sa, sb_sel, aop, rd, m2r, rw};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // One cycle of stimulus, called at posedge+1; pushes what the DUT must show this cycle.
  task automatic cyc(input int st, input logic mr, input logic [2:0] opv);
    exp_t e;
    op = opv;
    mem_ready = mr;
    e.st = st[3:0];
    e.ctrl = ctrl_of(st, mr);
    e.ret = exp_ret[3:0];
    e.ill = exp_ill;
    sb.push_back(e);
    exp_ill = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic retire_one();
    exp_ret = (exp_ret + 1) % CNT_MOD;
  endtask

  task automatic run_instr(input logic [2:0] o, input int fs, input int ms);
    for (int i = 0; i < fs; i++) cyc(0, 1'b0, rop());
    cyc(0, 1'b1, rop());
    cyc(1, rbit(), o);
    case (o)
      3'd0: begin cyc(6, rbit(), rop()); cyc(7, rbit(), rop()); retire_one(); end
      3'd1: begin
        cyc(2, rbit(), o);
        for (int i = 0; i < ms; i++) cyc(3, 1'b0, rop());
        cyc(3, 1'b1, rop());
        cyc(4, rbit(), rop());
        retire_one();
      end
      3'd2: begin
        cyc(2, rbit(), o);
        for (int i = 0; i < ms; i++) cyc(5, 1'b0, rop());
        cyc(5, 1'b1, rop());
        retire_one();
      end
      3'd3: begin cyc(8, rbit(), rop()); retire_one(); end
      3'd4: begin cyc(9, rbit(), rop()); cyc(10, rbit(), rop()); retire_one(); end
      3'd5: begin cyc(11, rbit(), rop()); retire_one(); end
      default: exp_ill = 1'b1;
    endcase
  endtask

  // SW whose MEMWR wait is cut short by an asynchronous reset.
  task automatic reset_mid_sw();
    cyc(0, 1'b1, rop());
    cyc(1, rbit(), 3'd2);
    cyc(2, rbit(), 3'd2);
    op = rop();
    mem_ready = 1'b0;
    #1;
    chk("pre_reset_state", 32'(state_o), 32'd5);
    chk("pre_reset_memwrite", 32'(memwrite), 32'd1);
    chk("pre_reset_retired", 32'(retired), 32'(exp_ret));
    mem_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("async_reset_state", 32'(state_o), 32'd0);
    chk("async_reset_memwrite", 32'(memwrite), 32'd0);
    chk("async_reset_retired", 32'(retired), 32'd0);
    chk("async_reset_mem_req", 32'(mem_req), 32'd0);
    chk("async_reset_irwrite", 32'(irwrite), 32'd0);
    @(posedge clk);
    #1;
    chk("held_reset_state", 32'(state_o), 32'd0);
    reset_n = 1'b1;
    exp_ret = 0;
    exp_ill = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {mem_req, iord, memwrite, irwrite, pcwrite, branch, pcsrc, alusrca,
               alusrcb, aluop, regdst, memtoreg, regwrite};
        checks++;
        if (state_o !== e.st || act !== e.ctrl || retired !== e.ret || illegal_op !== e.ill) begin
          errors++;
          $display("FAIL cycle_obs t=%0t: got st=%0d ctrl=%b ret=%0d ill=%b, expected st=%0d ctrl=%b ret=%0d ill=%b",
                   $time, state_o, act, retired, illegal_op, e.st, e.ctrl, e.ret, e.ill);
        end
      end
    end
  end

  initial begin : driver
    reset_n = 1'b0;
    mem_ready = 1'b1;
    op = 3'd0;
    #3;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    chk("reset_illegal", 32'(illegal_op), 32'd0);
    chk("reset_irwrite", 32'(irwrite), 32'd0);
    chk("reset_pcwrite", 32'(pcwrite), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk); @(posedge clk);
    #1;
    reset_n = 1'b1;

    // bring retired to 7, then reset in the middle of a store
    while (exp_ret != 7) run_instr(rop(), $urandom_range(0, 2), $urandom_range(0, 2));
    reset_mid_sw();

    run_instr(3'd1, 0, 0);  // LW, no stalls
    run_instr(3'd0, 3, 0);  // fetch stall
    run_instr(3'd2, 0, 2);  // SW stall
    run_instr(3'd3, 0, 0);
    run_instr(3'd5, 0, 0);
    run_instr(3'd4, 0, 0);
    run_instr(3'd6, 0, 0);  // illegal
    run_instr(3'd7, 0, 0);
    while (exp_ret != 15) run_instr(3'd0, 0, 0);
    run_instr(3'd0, 0, 0);  // wraps to 0
    cyc(0, 1'b0, rop());
    chk("wrap_retired", 32'(retired), 32'd0);

    for (int n = 0; n < 300; n++)
      run_instr(rop(), $urandom_range(0, 3), $urandom_range(0, 3));

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    drive_done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    if (!drive_done) begin
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule
